// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch buffer: sequential Sram reads, PC-tagged FIFO, valid/ready hand-off to decode.
// Define IFB_BYPASS_EN to forward a response straight to Inst when the queue is empty.
module inst_fetch_buffer #(
    parameter int D_WIDTH  = 32,
    parameter int SA_WIDTH = 8,
    parameter int DEPTH    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [SA_WIDTH-1:0]          start_pc_i,
    input  logic                         redirect_i,
    input  logic [SA_WIDTH-1:0]          redirect_pc_i,
    input  logic                         halt_i,
    output logic [SA_WIDTH-1:0]          mem_addr_o,
    output logic                         mem_rw_o,
    output logic                         mem_en_o,
    input  logic [D_WIDTH-1:0]           mem_data_i,
    output logic [D_WIDTH-1:0]           inst_o,
    output logic [SA_WIDTH-1:0]          inst_pc_o,
    output logic                         inst_valid_o,
    input  logic                         inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    state_e              state_q, state_d;
    logic [SA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [SA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                mem_en_q, mem_en_d;
    logic                rsp_pend_q, rsp_pend_d;
    logic [SA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [SA_WIDTH-1:0] base_pc;

    logic [D_WIDTH-1:0]  data_mem [DEPTH];
    logic [SA_WIDTH-1:0] pc_mem   [DEPTH];

    logic head_valid, bypass_take, consume, push, pop, credit_ok;

    assign head_valid = (count_q != '0);

`ifdef IFB_BYPASS_EN
    assign bypass_take  = rsp_pend_q && !head_valid && inst_ready_i;
    assign inst_valid_o = head_valid || rsp_pend_q;
    assign inst_o       = head_valid ? data_mem[rd_ptr_q] : (rsp_pend_q ? mem_data_i : '0);
    assign inst_pc_o    = head_valid ? pc_mem[rd_ptr_q]   : (rsp_pend_q ? rsp_pc_q   : '0);
`else
    assign bypass_take  = 1'b0;
    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc_o    = head_valid ? pc_mem[rd_ptr_q]   : '0;
`endif

    assign consume = inst_valid_o && inst_ready_i;
    assign push    = rsp_pend_q && !redirect_i && !bypass_take;
    assign pop     = head_valid && inst_ready_i && !redirect_i;

    // Queued words plus both outstanding read stages must leave room for one more read.
    assign credit_ok = (int'(count_q) + int'(rsp_pend_q) + int'(mem_en_q) - int'(consume)) < DEPTH;

    assign mem_addr_o = mem_addr_q;
    assign mem_en_o   = mem_en_q;
    assign mem_rw_o   = 1'b1;
    assign count_o    = count_q;

    always_comb begin
        state_d    = state_q;
        base_pc    = redirect_i ? redirect_pc_i : fetch_pc_q;
        fetch_pc_d = fetch_pc_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                state_d    = S_RUN;
                fetch_pc_d = start_pc_i;
            end
            S_RUN, S_HALT: begin
                state_d    = halt_i ? S_HALT : S_RUN;
                fetch_pc_d = base_pc;
                if (!halt_i && (redirect_i || credit_ok)) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = base_pc;
                    fetch_pc_d = base_pc + SA_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // A read issued before a redirect is killed by never marking its response pending.
        rsp_pend_d = mem_en_q && !redirect_i;
        rsp_pc_d   = mem_addr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            mem_addr_q <= '0;
            mem_en_q   <= 1'b0;
            rsp_pend_q <= 1'b0;
            rsp_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_en_q   <= mem_en_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_pc_q   <= rsp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_data_i;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(push && !pop && count_q == CW'(DEPTH)));

endmodule
